// File: rtl/dbg_pkg.sv
// Shared types and default sizing for the debug run-control sequencer.
package dbg_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HALTED  = 2'b01,
    STEP    = 2'b10,
    RSTHOLD = 2'b11
  } run_state_t;

  localparam int STEP_W_DEF   = 8;
  localparam int BRK_W_DEF    = 16;
  localparam int RST_HOLD_DEF = 4;
  localparam int RST_HOLD_MIN = 1;

  // A core that was stopped (halted or mid-step) stays stopped across a logic reset.
  function automatic run_state_t resume_target(input run_state_t prior);
    run_state_t tgt;
    case (prior)
      HALTED, STEP: tgt = HALTED;
      default:      tgt = RUN;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/dbg_run_controller_if.sv
// Strobe, configuration and status bundle between the JTAG CDC stage and the run controller.
interface dbg_run_controller_if
  import dbg_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF,
  parameter int BRK_W  = BRK_W_DEF
);

  logic              halt_stb;
  logic              step_stb;
  logic              resume_stb;
  logic              reset_stb;
  logic [STEP_W-1:0] step_count;
  logic              brk_en;
  logic [BRK_W-1:0]  brk_cycles;

  logic              clk_en;
  logic              dm_reset;
  logic              halted;
  logic [1:0]        run_state;
  logic              step_done;
  logic              brk_hit;

  modport slave (
    input  halt_stb, step_stb, resume_stb, reset_stb, step_count, brk_en, brk_cycles,
    output clk_en, dm_reset, halted, run_state, step_done, brk_hit
  );

  modport master (
    output halt_stb, step_stb, resume_stb, reset_stb, step_count, brk_en, brk_cycles,
    input  clk_en, dm_reset, halted, run_state, step_done, brk_hit
  );

endinterface

// File: rtl/dbg_pulse_stretch.sv
// Holds active_o high for RST_HOLD cycles after start_i; a new start_i reloads the count.
module dbg_pulse_stretch
  import dbg_pkg::*;
#(
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic active_o,
  output logic last_o
);

  localparam int HOLD = (RST_HOLD < RST_HOLD_MIN) ? RST_HOLD_MIN : RST_HOLD;
  localparam int CW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = LOAD;
    end else if (active_q) begin
      if (cnt_q == {CW{1'b0}}) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= {CW{1'b0}};
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign active_o = active_q;
  // Final held cycle: the owner leaves its hold state on this edge.
  assign last_o   = active_q && (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/dbg_run_controller.sv
// Sys_clk run-control sequencer: run/halt/step/reset-hold FSM driving the dbg_clk gate enable.
module dbg_run_controller
  import dbg_pkg::*;
#(
  parameter int STEP_W   = STEP_W_DEF,
  parameter int BRK_W    = BRK_W_DEF,
  parameter int RST_HOLD = RST_HOLD_DEF
) (
  input  logic                 sys_clk,
  input  logic                 dbg_rst,
  dbg_run_controller_if.slave  bus
);

  run_state_t        state_q, state_d;
  run_state_t        resume_mode_q, resume_mode_d;
  logic              clk_en_q, clk_en_d;
  logic              halted_q, halted_d;
  logic              step_done_q, step_done_d;
  logic              brk_hit_q, brk_hit_d;
  logic [BRK_W-1:0]  run_cnt_q, run_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;

  logic              hold_start_s;
  logic              hold_active_s;
  logic              hold_last_s;
  logic              brk_armed_s;
  logic              brk_term_s;
  logic [STEP_W-1:0] step_len_s;

  dbg_pulse_stretch #(
    .RST_HOLD (RST_HOLD)
  ) u_rst_hold (
    .clk_i    (sys_clk),
    .rst_ni   (dbg_rst),
    .start_i  (hold_start_s),
    .active_o (hold_active_s),
    .last_o   (hold_last_s)
  );

  // Breakpoint terminal count and effective step length.
  always_comb begin
    brk_armed_s = bus.brk_en && (bus.brk_cycles != {BRK_W{1'b0}});
    if (brk_armed_s) begin
      brk_term_s = (run_cnt_q == (bus.brk_cycles - BRK_W'(1)));
    end else begin
      brk_term_s = 1'b0;
    end
    if (bus.step_count == {STEP_W{1'b0}}) begin
      step_len_s = STEP_W'(1);
    end else begin
      step_len_s = bus.step_count;
    end
  end

  always_comb begin
    state_d       = state_q;
    resume_mode_d = resume_mode_q;
    clk_en_d      = clk_en_q;
    step_done_d   = 1'b0;
    brk_hit_d     = 1'b0;
    run_cnt_d     = run_cnt_q;
    step_cnt_d    = step_cnt_q;
    hold_start_s  = 1'b0;

    if (bus.reset_stb) begin
      // Re-entry keeps the original resume target; only the hold count restarts.
      state_d      = RSTHOLD;
      clk_en_d     = 1'b1;
      hold_start_s = 1'b1;
      run_cnt_d    = {BRK_W{1'b0}};
      step_cnt_d   = {STEP_W{1'b0}};
      if (state_q != RSTHOLD) begin
        resume_mode_d = resume_target(state_q);
      end else begin
        resume_mode_d = resume_mode_q;
      end
    end else begin
      case (state_q)
        RUN: begin
          clk_en_d = 1'b1;
          if (brk_armed_s) begin
            run_cnt_d = run_cnt_q + BRK_W'(1);
          end else begin
            run_cnt_d = {BRK_W{1'b0}};
          end
          if (brk_term_s || bus.halt_stb) begin
            state_d   = HALTED;
            clk_en_d  = 1'b0;
            brk_hit_d = brk_term_s;
            run_cnt_d = {BRK_W{1'b0}};
          end else begin
            state_d = RUN;
          end
        end

        HALTED: begin
          clk_en_d = 1'b0;
          if (bus.step_stb) begin
            state_d    = STEP;
            clk_en_d   = 1'b1;
            step_cnt_d = step_len_s;
          end else if (bus.resume_stb) begin
            state_d   = RUN;
            clk_en_d  = 1'b1;
            run_cnt_d = {BRK_W{1'b0}};
          end else begin
            state_d = HALTED;
          end
        end

        STEP: begin
          clk_en_d   = 1'b1;
          step_cnt_d = step_cnt_q - STEP_W'(1);
          if (bus.halt_stb) begin
            state_d    = HALTED;
            clk_en_d   = 1'b0;
            step_cnt_d = {STEP_W{1'b0}};
          end else if (bus.resume_stb) begin
            state_d    = RUN;
            run_cnt_d  = {BRK_W{1'b0}};
            step_cnt_d = {STEP_W{1'b0}};
          end else if (step_cnt_q <= STEP_W'(1)) begin
            state_d     = HALTED;
            clk_en_d    = 1'b0;
            step_done_d = 1'b1;
            step_cnt_d  = {STEP_W{1'b0}};
          end else begin
            state_d = STEP;
          end
        end

        RSTHOLD: begin
          clk_en_d = 1'b1;
          if (hold_last_s) begin
            state_d   = resume_mode_q;
            clk_en_d  = (resume_mode_q != HALTED);
            run_cnt_d = {BRK_W{1'b0}};
          end else begin
            state_d = RSTHOLD;
          end
        end

        default: begin
          state_d  = RUN;
          clk_en_d = 1'b1;
        end
      endcase
    end

    halted_d = (state_d == HALTED);
  end

  // Reset state runs the core, so the gate comes up enabled.
  always_ff @(posedge sys_clk or negedge dbg_rst) begin
    if (!dbg_rst) begin
      state_q       <= RUN;
      resume_mode_q <= RUN;
      clk_en_q      <= 1'b1;
      halted_q      <= 1'b0;
      step_done_q   <= 1'b0;
      brk_hit_q     <= 1'b0;
      run_cnt_q     <= {BRK_W{1'b0}};
      step_cnt_q    <= {STEP_W{1'b0}};
    end else begin
      state_q       <= state_d;
      resume_mode_q <= resume_mode_d;
      clk_en_q      <= clk_en_d;
      halted_q      <= halted_d;
      step_done_q   <= step_done_d;
      brk_hit_q     <= brk_hit_d;
      run_cnt_q     <= run_cnt_d;
      step_cnt_q    <= step_cnt_d;
    end
  end

  assign bus.clk_en    = clk_en_q;
  assign bus.dm_reset  = hold_active_s;
  assign bus.halted    = halted_q;
  assign bus.run_state = state_q;
  assign bus.step_done = step_done_q;
  assign bus.brk_hit   = brk_hit_q;

endmodule
